// File: rtl/decode_onehot_seq_if.sv
// rtl/decode_onehot_seq_if.sv - load/rotate control and one-hot result bundle for decode_onehot_seq
interface decode_onehot_seq_if #(
    parameter int SEL_W = 3
);
    localparam int OUT_W = 2 ** SEL_W;

    logic [SEL_W-1:0] sel_in;
    logic             load_valid;
    logic             load_ready;
    logic             clear;
    logic             rot_start;
    logic             rot_stop;
    logic             dir;
    logic [OUT_W-1:0] res;
    logic             out_valid;
    logic [1:0]       state;
    logic             wrap;

    modport master (
        output sel_in, load_valid, clear, rot_start, rot_stop, dir,
        input  load_ready, res, out_valid, state, wrap
    );

    modport slave (
        input  sel_in, load_valid, clear, rot_start, rot_stop, dir,
        output load_ready, res, out_valid, state, wrap
    );
endinterface

// File: rtl/decode_onehot_seq.sv
// rtl/decode_onehot_seq.sv - registered one-hot decoder with ring rotation; ONEHOT_CHECK_EN adds err_onehot
module decode_onehot_seq #(
    parameter int SEL_W     = 3,
    parameter int MAX_STEPS = 0,
    parameter int CNT_W     = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    decode_onehot_seq_if.slave  bus
`ifdef ONEHOT_CHECK_EN
    ,
    output logic                err_onehot
`endif
);
    localparam int OUT_W = 2 ** SEL_W;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_ROT  = 2'b10;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
    localparam bit               BOUNDED = (MAX_STEPS != 0);

    logic [1:0]       state_q;
    logic [SEL_W-1:0] idx_q;
    logic [CNT_W-1:0] step_cnt;
    logic             wrap_q;

    logic             rotating;
    logic             load_ready;
    logic             load_acc;
    logic             valid;
    logic [SEL_W-1:0] idx_step;
    logic             at_edge;
    logic [CNT_W-1:0] cnt_next;
    logic [OUT_W-1:0] res;

    assign rotating   = (state_q == ST_ROT);
    assign load_ready = !rotating;
    assign load_acc   = bus.load_valid && load_ready;
    assign valid      = (state_q == ST_HOLD) || (state_q == ST_ROT);

    // Modular SEL_W-bit arithmetic gives the ring wrap for free.
    assign idx_step = bus.dir ? (idx_q - 1'b1) : (idx_q + 1'b1);
    assign at_edge  = bus.dir ? (idx_q == '0) : (idx_q == '1);
    assign cnt_next = step_cnt + 1'b1;

    assign res = valid ? (OUT_W'(1) << idx_q) : '0;

    assign bus.load_ready = load_ready;
    assign bus.out_valid  = valid;
    assign bus.res        = res;
    assign bus.state      = state_q;
    assign bus.wrap       = wrap_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            step_cnt <= '0;
            wrap_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (bus.clear) begin
                state_q  <= ST_IDLE;
                idx_q    <= '0;
                step_cnt <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (load_acc) begin
                            idx_q   <= bus.sel_in;
                            state_q <= ST_HOLD;
                        end
                    end
                    ST_HOLD: begin
                        if (load_acc) begin
                            idx_q <= bus.sel_in;
                        end else if (bus.rot_start) begin
                            state_q  <= ST_ROT;
                            step_cnt <= '0;
                        end
                    end
                    ST_ROT: begin
                        if (bus.rot_stop) begin
                            state_q <= ST_HOLD;
                        end else begin
                            idx_q    <= idx_step;
                            step_cnt <= cnt_next;
                            wrap_q   <= at_edge;
                            // Bounded mode: the final step is still taken before parking.
                            if (BOUNDED && (cnt_next == MAX_CNT)) begin
                                state_q <= ST_HOLD;
                            end
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        idx_q    <= '0;
                        step_cnt <= '0;
                    end
                endcase
            end
        end
    end

`ifdef ONEHOT_CHECK_EN
    logic bad_now;

    assign bad_now = valid ? ($countones(res) != 1) : (res != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_onehot <= 1'b0;
        end else if (bus.clear) begin
            err_onehot <= 1'b0;
        end else if (bad_now) begin
            err_onehot <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_decode_onehot_seq.sv
// tb/tb_decode_onehot_seq.sv - model-checked random and directed bench for decode_onehot_seq
module tb_decode_onehot_seq;
    logic       clock;
    logic       reset_n;
    logic [2:0] sel_in;
    logic       load_valid;
    logic       clear;
    logic       rot_start;
    logic       rot_stop;
    logic       dir;
    logic       check_en;

    int total = 0;
    int bad   = 0;

    decode_onehot_seq_if #(.SEL_W(3)) bus_a ();
    decode_onehot_seq_if #(.SEL_W(3)) bus_b ();
    decode_onehot_seq_if #(.SEL_W(1)) bus_c ();

    assign bus_a.sel_in = sel_in;      assign bus_b.sel_in = sel_in;      assign bus_c.sel_in = sel_in[0];
    assign bus_a.load_valid = load_valid; assign bus_b.load_valid = load_valid; assign bus_c.load_valid = load_valid;
    assign bus_a.clear = clear;        assign bus_b.clear = clear;        assign bus_c.clear = clear;
    assign bus_a.rot_start = rot_start; assign bus_b.rot_start = rot_start; assign bus_c.rot_start = rot_start;
    assign bus_a.rot_stop = rot_stop;  assign bus_b.rot_stop = rot_stop;  assign bus_c.rot_stop = rot_stop;
    assign bus_a.dir = dir;            assign bus_b.dir = dir;            assign bus_c.dir = dir;

`ifdef ONEHOT_CHECK_EN
    logic err_a, err_b, err_c;
`endif

    decode_onehot_seq #(.SEL_W(3), .MAX_STEPS(0), .CNT_W(8)) dut_a (
        .clock(clock), .reset_n(reset_n), .bus(bus_a)
`ifdef ONEHOT_CHECK_EN
        , .err_onehot(err_a)
`endif
    );
    decode_onehot_seq #(.SEL_W(3), .MAX_STEPS(4), .CNT_W(8)) dut_b (
        .clock(clock), .reset_n(reset_n), .bus(bus_b)
`ifdef ONEHOT_CHECK_EN
        , .err_onehot(err_b)
`endif
    );
    decode_onehot_seq #(.SEL_W(1), .MAX_STEPS(0), .CNT_W(8)) dut_c (
        .clock(clock), .reset_n(reset_n), .bus(bus_c)
`ifdef ONEHOT_CHECK_EN
        , .err_onehot(err_c)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Reference model: mode 0 idle, 1 holding, 2 rotating; ring size and step limit per instance.
    int m_mode[3];
    int m_idx[3];
    int m_cnt[3];
    int m_wrap[3];

    function automatic int ring(input int i);
        return (i == 2) ? 2 : 8;
    endfunction

    function automatic int limit(input int i);
        return (i == 1) ? 4 : 0;
    endfunction

    function automatic void model_next(input int mode, input int idx, input int cnt,
                                       input int ow, input int maxs,
                                       output int nmode, output int nidx,
                                       output int ncnt, output int nwrap);
        nmode = mode; nidx = idx; ncnt = cnt; nwrap = 0;
        if (clear) begin
            nmode = 0; nidx = 0; ncnt = 0;
        end else if (mode != 2 && load_valid) begin
            nmode = 1; nidx = int'(sel_in) % ow;
        end else if (mode == 2 && rot_stop) begin
            nmode = 1;
        end else if (mode == 1 && rot_start) begin
            nmode = 2; ncnt = 0;
        end else if (mode == 2) begin
            nidx  = dir ? (idx + ow - 1) % ow : (idx + 1) % ow;
            nwrap = dir ? int'(idx == 0) : int'(idx == ow - 1);
            ncnt  = cnt + 1;
            if (maxs != 0 && ncnt == maxs) nmode = 1;
        end
    endfunction

    always @(posedge clock or negedge reset_n) begin
        int nm, ni, nc, nw;
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                m_mode[i] <= 0; m_idx[i] <= 0; m_cnt[i] <= 0; m_wrap[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                model_next(m_mode[i], m_idx[i], m_cnt[i], ring(i), limit(i), nm, ni, nc, nw);
                m_mode[i] <= nm; m_idx[i] <= ni; m_cnt[i] <= nc; m_wrap[i] <= nw;
            end
        end
    end

    // {res[7:0], out_valid, state[1:0], wrap, load_ready}
    function automatic logic [12:0] exp_vec(input int i);
        logic [7:0] r;
        r = (m_mode[i] != 0) ? 8'(1 << m_idx[i]) : 8'h00;
        return {r, m_mode[i] != 0, 2'(m_mode[i]), m_wrap[i] != 0, m_mode[i] != 2};
    endfunction

    logic [12:0] act_a, act_b, act_c, ev;
    assign act_a = {bus_a.res, bus_a.out_valid, bus_a.state, bus_a.wrap, bus_a.load_ready};
    assign act_b = {bus_b.res, bus_b.out_valid, bus_b.state, bus_b.wrap, bus_b.load_ready};
    assign act_c = {6'b0, bus_c.res, bus_c.out_valid, bus_c.state, bus_c.wrap, bus_c.load_ready};

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            chk("cmp_a", {3'b0, act_a}, {3'b0, exp_vec(0)});
            chk("cmp_b", {3'b0, act_b}, {3'b0, exp_vec(1)});
            chk("cmp_c", {3'b0, act_c}, {3'b0, exp_vec(2)});
`ifdef ONEHOT_CHECK_EN
            chk("err_onehot", {13'b0, err_a, err_b, err_c}, 16'h0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clock);
        #2;
    endtask

    task automatic quiet();
        load_valid = 1'b0; clear = 1'b0; rot_start = 1'b0; rot_stop = 1'b0;
    endtask

    initial begin
        check_en = 1'b0;
        reset_n  = 1'b0;
        sel_in   = 3'd0;
        dir      = 1'b0;
        quiet();
        repeat (2) cyc();
        reset_n  = 1'b1;
        check_en = 1'b1;
        chk("reset_state", {3'b0, act_a}, 16'h0001);

        // load 5 from IDLE
        load_valid = 1'b1; sel_in = 3'd5;
        cyc(); quiet();
        chk("load5_res", 16'(bus_a.res), 16'h0020);
        chk("load5_state", 16'(bus_a.state), 16'h0001);
        chk("load5_ready", 16'(bus_a.load_ready), 16'h0001);
        ev = exp_vec(0);
        chk("model_load5", 16'(ev[12:5]), 16'h0020);

        // up rotation through 7 -> 0
        load_valid = 1'b1; sel_in = 3'd6;
        cyc(); quiet();
        rot_start = 1'b1; dir = 1'b0;
        cyc(); quiet();
        chk("up_c1", {7'b0, bus_a.res, bus_a.wrap}, {7'b0, 8'h40, 1'b0});
        cyc();
        chk("up_c2", {7'b0, bus_a.res, bus_a.wrap}, {7'b0, 8'h80, 1'b0});
        cyc();
        chk("up_c3", {7'b0, bus_a.res, bus_a.wrap}, {7'b0, 8'h01, 1'b1});
        cyc();
        chk("up_c4", {7'b0, bus_a.res, bus_a.wrap}, {7'b0, 8'h02, 1'b0});
        rot_stop = 1'b1;
        cyc(); quiet();
        chk("up_stop", 16'(bus_a.state), 16'h0001);

        // down step 0 -> 7, then stop
        load_valid = 1'b1; sel_in = 3'd0;
        cyc(); quiet();
        rot_start = 1'b1; dir = 1'b1;
        cyc(); quiet();
        chk("dn_entry", {6'b0, bus_a.res, bus_a.state}, {6'b0, 8'h01, 2'b10});
        cyc();
        chk("dn_step", {7'b0, bus_a.res, bus_a.wrap}, {7'b0, 8'h80, 1'b1});
        rot_stop = 1'b1;
        cyc(); quiet();
        chk("dn_stop", {5'b0, bus_a.res, bus_a.state, bus_a.wrap}, {5'b0, 8'h80, 2'b01, 1'b0});

        // bounded rotation on dut_b
        load_valid = 1'b1; sel_in = 3'd2;
        cyc(); quiet();
        rot_start = 1'b1; dir = 1'b0;
        cyc(); quiet();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("bounded_res", 16'(bus_b.res), 16'(8'h08 << k));
            chk("bounded_state", 16'(bus_b.state), (k == 3) ? 16'h0001 : 16'h0002);
        end
        chk("bounded_ready", 16'(bus_b.load_ready), 16'h0001);
        clear = 1'b1;
        cyc(); quiet();

        // load beats rot_start; clear beats load
        load_valid = 1'b1; sel_in = 3'd3;
        cyc(); quiet();
        load_valid = 1'b1; sel_in = 3'd1; rot_start = 1'b1;
        cyc(); quiet();
        chk("ld_rs_res", {6'b0, bus_a.res, bus_a.state}, {6'b0, 8'h02, 2'b01});
        clear = 1'b1; load_valid = 1'b1; sel_in = 3'd4;
        cyc(); quiet();
        chk("clr_ld", {5'b0, bus_a.res, bus_a.out_valid, bus_a.state}, 16'h0000);

        // async reset while a wrap pulse is showing
        load_valid = 1'b1; sel_in = 3'd7;
        cyc(); quiet();
        rot_start = 1'b1; dir = 1'b0;
        cyc(); quiet();
        cyc();
        chk("pre_rst_wrap", 16'(bus_a.wrap), 16'h0001);
        reset_n = 1'b0;
        #1;
        chk("async_rst", {4'b0, bus_a.res, bus_a.out_valid, bus_a.state, bus_a.wrap}, 16'h0000);
        cyc();
        reset_n = 1'b1;

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc();
            sel_in     = 3'($urandom_range(0, 7));
            dir        = 1'($urandom_range(0, 1));
            load_valid = ($urandom_range(0, 99) < 30);
            clear      = ($urandom_range(0, 99) < 3);
            rot_start  = ($urandom_range(0, 99) < 25);
            rot_stop   = ($urandom_range(0, 99) < 8);
            reset_n    = ($urandom_range(0, 999) >= 5);
        end
        cyc();
        quiet();
        reset_n = 1'b1;
        repeat (2) cyc();
        check_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
